biset_arbiter: RTL and testbench



---
 rtl/biset_arbiter.sv | 123 ++++++++++++
 tb/tb_biset_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/biset_arbiter.sv
// BiSet bus types plus a pipelined round-robin arbiter that shares one BiSet bus among N requesters.
// Optional macro BISET_ARB_LOCK_EN adds lock_i so the last grantee can hold the bus for atomic sequences.
package BiSet;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
    } biSetCtrl;

    typedef logic [DATA_W-1:0] biSetData;
    typedef logic [DATA_W-1:0] biSetReply;
endpackage

// Handshake: a request on req_i is consumed in the cycle its gnt_o bit is high; the matching
// rvalid_o bit (with rdata_o) follows exactly three cycles later, for reads and writes alike.
module biset_arbiter #(
    parameter int N = 4,
    localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
`ifdef BISET_ARB_LOCK_EN
    input  logic [N-1:0]              lock_i,
`endif
    input  logic [N-1:0]              req_i,
    input  BiSet::biSetCtrl [N-1:0]   reqCtrl_i,
    input  BiSet::biSetData [N-1:0]   reqData_i,
    output logic [N-1:0]              gnt_o,
    output logic [N-1:0]              rvalid_o,
    output BiSet::biSetReply          rdata_o,
    output BiSet::biSetCtrl           setCtrl_o,
    output BiSet::biSetData           setWrite_o,
    input  BiSet::biSetReply          setReply_i
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_nxt;
    logic [N-1:0]   eligible;
    logic           gnt_any;
    logic           gnt_fire;
    logic [IDW-1:0] gnt_id;
    int             idx;

    logic           s1_vld_q;
    logic [IDW-1:0] s1_id_q;
    logic           s2_vld_q;
    logic [IDW-1:0] s2_id_q;

`ifdef BISET_ARB_LOCK_EN
    logic           last_vld_q;
    logic [IDW-1:0] last_id_q;
    logic           locked;

    // While the last grantee keeps its lock bit high, only it may be granted again.
    assign locked   = last_vld_q && lock_i[last_id_q];
    assign eligible = locked ? (req_i & (ONE << last_id_q)) : req_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_vld_q <= 1'b0;
            last_id_q  <= '0;
        end else if (gnt_fire) begin
            last_vld_q <= 1'b1;
            last_id_q  <= gnt_id;
        end
    end
`else
    assign eligible = req_i;
`endif

    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N) idx = idx - N;
            if (!gnt_any && eligible[IDW'(idx)]) begin
                gnt_any = 1'b1;
                gnt_id  = IDW'(idx);
            end
        end
    end

    assign gnt_fire = gnt_any & rst_ni;
    assign gnt_o    = gnt_fire ? (ONE << gnt_id) : '0;
    assign ptr_nxt  = (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q      <= '0;
            setCtrl_o  <= '0;
            setWrite_o <= '0;
            s1_vld_q   <= 1'b0;
            s1_id_q    <= '0;
            s2_vld_q   <= 1'b0;
            s2_id_q    <= '0;
            rvalid_o   <= '0;
            rdata_o    <= '0;
        end else begin
            s1_vld_q <= gnt_fire;
            s1_id_q  <= gnt_id;
            if (gnt_fire) begin
                ptr_q      <= ptr_nxt;
                setCtrl_o  <= reqCtrl_i[gnt_id];
                setWrite_o <= reqData_i[gnt_id];
            end else begin
                setCtrl_o  <= '0;
                setWrite_o <= '0;
            end
            // The slave replies one cycle after sampling, so the tag waits one extra stage.
            s2_vld_q <= s1_vld_q;
            s2_id_q  <= s1_id_q;
            rvalid_o <= s2_vld_q ? (ONE << s2_id_q) : '0;
            if (s2_vld_q) rdata_o <= setReply_i;
        end
    end

endmodule

// File: tb/tb_biset_arbiter.sv
// Self-checking bench for biset_arbiter: BiSet register-file slave, round-robin reference model
// and a reply scoreboard; exercises lock_i when built with BISET_ARB_LOCK_EN.
module tb_biset_arbiter;
    localparam int N = 4;
    localparam int W = 32 + N + 32;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [N-1:0]            req;
    BiSet::biSetCtrl [N-1:0] ctrl;
    BiSet::biSetData [N-1:0] wdata;
    logic [N-1:0]            gnt_o;
    logic [N-1:0]            rvalid_o;
    BiSet::biSetReply        rdata_o;
    BiSet::biSetCtrl         setCtrl_o;
    BiSet::biSetData         setWrite_o;
    BiSet::biSetReply        slave_reply;
`ifdef BISET_ARB_LOCK_EN
    logic [N-1:0]            lock;
`endif

    always #5 clk = ~clk;

    biset_arbiter #(.N(N)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
`ifdef BISET_ARB_LOCK_EN
        .lock_i     (lock),
`endif
        .req_i      (req),
        .reqCtrl_i  (ctrl),
        .reqData_i  (wdata),
        .gnt_o      (gnt_o),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o),
        .setCtrl_o  (setCtrl_o),
        .setWrite_o (setWrite_o),
        .setReply_i (slave_reply)
    );

    // BiSet register-file slave: samples the bus, replies one cycle later (writes echo the stored value).
    logic        slave_clr;
    logic [31:0] mem [16];
    always @(posedge clk) begin
        if (slave_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'hA000_0000 | 32'(i);
            slave_reply <= '0;
        end else if (setCtrl_o.we) begin
            mem[setCtrl_o.addr[3:0]] <= setWrite_o;
            slave_reply              <= setWrite_o;
        end else begin
            slave_reply <= mem[setCtrl_o.addr[3:0]];
        end
    end

    // Reference model and scoreboard state.
    logic [W-1:0]    exp_q[$];
    logic [31:0]     ref_mem [16];
    BiSet::biSetCtrl exp_ctrl;
    BiSet::biSetData exp_wr;
    int              ptr_m;
    int              last_vld_m;
    int              last_id_m;
    logic [N-1:0]    last_gnt;
    logic [N-1:0]    obs_gnt;
    logic [N-1:0]    one = 1;
    int              cycle;
    int              checks;
    int              failures;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cycle);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        ptr_m      = 0;
        last_vld_m = 0;
        last_id_m  = 0;
        exp_ctrl   = '0;
        exp_wr     = '0;
        last_gnt   = '0;
    endtask

    // One clock cycle: check the DUT against the model at the falling edge, then advance the model.
    task automatic step();
        logic [N-1:0]    elig;
        logic [N-1:0]    exp_gnt;
        logic [W-1:0]    e;
        logic [31:0]     rd;
        BiSet::biSetCtrl c;
        int              w;
        @(negedge clk);
        elig = req;
`ifdef BISET_ARB_LOCK_EN
        if (last_vld_m != 0 && lock[last_id_m]) elig = req & (one << last_id_m);
`endif
        w = -1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (ptr_m + k) % N;
            if (w < 0 && elig[j]) w = j;
        end
        exp_gnt = (w >= 0) ? (one << w) : '0;
        obs_gnt = gnt_o;
        check("gnt", gnt_o, exp_gnt);
        check("set_ctrl", setCtrl_o, exp_ctrl);
        check("set_write", setWrite_o, exp_wr);
        if (exp_q.size() > 0 && exp_q[0][W-1 -: 32] == 32'(cycle)) begin
            e = exp_q.pop_front();
            check("rvalid", rvalid_o, e[N+31:32]);
            check("rdata", rdata_o, e[31:0]);
        end else begin
            check("rvalid_idle", rvalid_o, '0);
        end
        if (w >= 0) begin
            c  = ctrl[w];
            rd = c.we ? wdata[w] : ref_mem[c.addr[3:0]];
            if (c.we) ref_mem[c.addr[3:0]] = wdata[w];
            exp_q.push_back({32'(cycle + 3), exp_gnt, rd});
            exp_ctrl   = c;
            exp_wr     = wdata[w];
            ptr_m      = (w + 1) % N;
            last_vld_m = 1;
            last_id_m  = w;
            last_gnt   = exp_gnt;
        end else begin
            exp_ctrl = '0;
            exp_wr   = '0;
            last_gnt = '0;
        end
        cycle++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    // Assert reset with whatever is in flight; everything pending is dropped.
    task automatic pulse_reset();
        rst_n = 1'b0;
        clear_model();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_gnt", gnt_o, '0);
            check("rst_rvalid", rvalid_o, '0);
            check("rst_ctrl", setCtrl_o, '0);
            check("rst_write", setWrite_o, '0);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        cycle     = 0;
        rst_n     = 1'b0;
        slave_clr = 1'b1;
        req       = '0;
        ctrl      = '0;
        wdata     = '0;
`ifdef BISET_ARB_LOCK_EN
        lock      = '0;
`endif
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'hA000_0000 | 32'(i);
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        slave_clr = 1'b0;
        @(negedge clk);
        check("reset_gnt", gnt_o, '0);
        check("reset_rvalid", rvalid_o, '0);
        check("reset_rdata", rdata_o, '0);
        check("reset_ctrl", setCtrl_o, '0);
        check("reset_write", setWrite_o, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle bus after reset.
        idle(10);

        // All requesters busy from pointer 0: strict rotation without bubbles.
        req = '1;
        for (int i = 0; i < N; i++) begin
            ctrl[i].addr = 16'(i);
            ctrl[i].we   = (i % 2) == 1;
            wdata[i]     = 32'hC0DE_0000 | 32'(i);
        end
        for (int k = 0; k < 8; k++) begin
            step();
            check("rr_seq", obs_gnt, one << (k % N));
        end
        idle(4);

        // Requester 2 alone writes addr 5, then reads it back.
        req      = 4'b0100;
        ctrl[2]  = '{addr: 16'd5, we: 1'b1};
        wdata[2] = 32'h1234_5678;
        step();
        check("solo_write_gnt", obs_gnt, 4'b0100);
        idle(4);
        req     = 4'b0100;
        ctrl[2] = '{addr: 16'd5, we: 1'b0};
        step();
        idle(4);

        // Pointer at 0 with requesters 1 and 3, then requester 0 joins.
        pulse_reset();
        ctrl = '0;
        req  = 4'b1010;
        step();
        check("alt_first", obs_gnt, 4'b0010);
        step();
        check("alt_second", obs_gnt, 4'b1000);
        req = 4'b1011;
        step();
        check("join_r0", obs_gnt, 4'b0001);
        for (int k = 0; k < 5; k++) step();
        idle(4);

        // Reset with three reads in flight; first grant afterwards goes to requester 0.
        for (int i = 0; i < N; i++) ctrl[i] = '{addr: 16'(i + 8), we: 1'b0};
        req = '1;
        for (int k = 0; k < 3; k++) step();
        pulse_reset();
        step();
        check("post_reset_gnt", obs_gnt, 4'b0001);
        for (int k = 0; k < 3; k++) step();
        idle(4);

        // Random traffic that honours hold-until-grant and allows withdrawal.
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] || last_gnt[i]) begin
                    req[i]       = 1'($urandom_range(0, 1));
                    ctrl[i].addr = 16'($urandom_range(0, 15));
                    ctrl[i].we   = 1'($urandom_range(0, 1));
                    wdata[i]     = $urandom;
                end
            end
            step();
        end
        idle(4);

`ifdef BISET_ARB_LOCK_EN
        // Requester 1 locks for a read-modify-write while requester 0 keeps asking.
        lock     = 4'b0010;
        req      = 4'b0010;
        ctrl[1]  = '{addr: 16'd3, we: 1'b0};
        step();
        check("lock_read", obs_gnt, 4'b0010);
        req      = 4'b0011;
        ctrl[0]  = '{addr: 16'd7, we: 1'b0};
        ctrl[1]  = '{addr: 16'd3, we: 1'b1};
        wdata[1] = 32'hFEED_0003;
        step();
        check("lock_write", obs_gnt, 4'b0010);
        req = 4'b0001;
        step();
        check("lock_hold", obs_gnt, 4'b0000);
        step();
        check("lock_hold2", obs_gnt, 4'b0000);
        lock = '0;
        step();
        check("lock_release", obs_gnt, 4'b0001);
        idle(4);
`endif

        check("drain", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
